// File: rtl/mem_w_commit.sv
// Purpose: in-order store commit buffer between the execute stage and the data-memory write bus.
// Latency: 2 cycles from push to bus_w_req; consecutive acks drain back-to-back with no bubble.
// Backpressure: mem_w_ready low while full; a store arriving while full is dropped and sets err_ovf.
//
// Ports:
//   sys_clk, sys_rst_n            clock (posedge) and asynchronous active-low reset
//   mem_w_op/_mem_addr/_mem_val   store request from execute (sampled on posedge)
//   mem_w_ready                   FIFO not full
//   bus_w_req/_addr/_data/_ack    write request to data memory, held stable until ack or timeout
//   idle                          FIFO empty and no request in flight
//   err_ovf, err_tmo, err_clr     sticky overflow / bus-timeout flags and their synchronous clear
// Optional: define MEM_W_FWD_EN to add ld_addr/fwd_hit/fwd_val store-to-load forwarding.
module mem_w_commit #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        mem_w_op,
  input  logic [31:0] mem_w_mem_addr,
  input  logic [31:0] mem_w_mem_val,
  output logic        mem_w_ready,
  output logic        bus_w_req,
  output logic [31:0] bus_w_addr,
  output logic [31:0] bus_w_data,
  input  logic        bus_w_ack,
`ifdef MEM_W_FWD_EN
  input  logic [31:0] ld_addr,
  output logic        fwd_hit,
  output logic [31:0] fwd_val,
`endif
  output logic        idle,
  output logic        err_ovf,
  output logic        err_tmo,
  input  logic        err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  // Counter is cleared on launch, so the head is dropped on the TIMEOUT-th unacked edge.
  localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_addr_mem [DEPTH];
  logic [31:0]   r_data_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr, r_wr_ptr, w_rd_ptr_inc;
  logic [CW-1:0] r_count;
  logic [7:0]    r_tmo_cnt, w_tmo_cnt_nxt;
  logic          r_bus_req, w_bus_req_nxt;
  logic [31:0]   r_bus_addr, w_bus_addr_nxt;
  logic [31:0]   r_bus_data, w_bus_data_nxt;
  logic          r_err_ovf, r_err_tmo;
  logic          w_full, w_push, w_pop, w_ovf, w_tmo;

  // Full comes from the registered count only: a pop in the same cycle does not make room.
  assign w_full       = (r_count == FULL_CNT);
  assign w_push       = mem_w_op && !w_full;
  assign w_ovf        = mem_w_op && w_full;
  assign w_rd_ptr_inc = r_rd_ptr + AW'(1);

  assign mem_w_ready = !w_full;
  assign idle        = (r_count == '0) && (r_state == S_IDLE);
  assign bus_w_req   = r_bus_req;
  assign bus_w_addr  = r_bus_addr;
  assign bus_w_data  = r_bus_data;
  assign err_ovf     = r_err_ovf;
  assign err_tmo     = r_err_tmo;

  // Storage needs no reset: validity is tracked by r_count and the pointers.
  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_addr_mem[r_wr_ptr] <= mem_w_mem_addr;
      r_data_mem[r_wr_ptr] <= mem_w_mem_val;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_bus_req_nxt  = r_bus_req;
    w_bus_addr_nxt = r_bus_addr;
    w_bus_data_nxt = r_bus_data;
    w_tmo_cnt_nxt  = r_tmo_cnt;
    w_pop          = 1'b0;
    w_tmo          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_bus_addr_nxt = r_addr_mem[r_rd_ptr];
          w_bus_data_nxt = r_data_mem[r_rd_ptr];
          w_bus_req_nxt  = 1'b1;
          w_tmo_cnt_nxt  = '0;
          w_state_nxt    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus_w_ack) begin
          // Ack beats a coincident timeout.
          w_pop         = 1'b1;
          w_tmo_cnt_nxt = '0;
          if (r_count > CW'(1)) begin
            w_bus_addr_nxt = r_addr_mem[w_rd_ptr_inc];
            w_bus_data_nxt = r_data_mem[w_rd_ptr_inc];
          end else if (w_push) begin
            // Only entry left is being pushed this cycle and is not in storage yet.
            w_bus_addr_nxt = mem_w_mem_addr;
            w_bus_data_nxt = mem_w_mem_val;
          end else begin
            w_bus_req_nxt = 1'b0;
            w_state_nxt   = S_IDLE;
          end
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_pop         = 1'b1;
          w_tmo         = 1'b1;
          w_tmo_cnt_nxt = '0;
          w_bus_req_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_bus_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_tmo_cnt  <= '0;
      r_bus_req  <= 1'b0;
      r_bus_addr <= '0;
      r_bus_data <= '0;
      r_err_ovf  <= 1'b0;
      r_err_tmo  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      r_tmo_cnt  <= w_tmo_cnt_nxt;
      r_bus_req  <= w_bus_req_nxt;
      r_bus_addr <= w_bus_addr_nxt;
      r_bus_data <= w_bus_data_nxt;
      // Set has priority over clear.
      r_err_ovf  <= w_ovf ? 1'b1 : (err_clr ? 1'b0 : r_err_ovf);
      r_err_tmo  <= w_tmo ? 1'b1 : (err_clr ? 1'b0 : r_err_tmo);
    end
  end

`ifdef MEM_W_FWD_EN
  // Scan oldest to youngest so the youngest match is left standing. The in-flight head
  // still occupies slot r_rd_ptr until it is popped, so it is covered by the scan too.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) && (r_addr_mem[r_rd_ptr + AW'(i)] == ld_addr)) begin
        fwd_hit = 1'b1;
        fwd_val = r_data_mem[r_rd_ptr + AW'(i)];
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_w_commit.sv
module tb_mem_w_commit;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        mem_w_op, bus_w_ack, err_clr;
  logic [31:0] mem_w_mem_addr, mem_w_mem_val;
  logic        mem_w_ready, bus_w_req, idle, err_ovf, err_tmo;
  logic [31:0] bus_w_addr, bus_w_data;

  logic        t_op, t_ack, t_clr;
  logic [31:0] t_addr, t_val;
  logic        t_ready, t_req, t_idle, t_ovf, t_tmo;
  logic [31:0] t_baddr, t_bdata;

`ifdef MEM_W_FWD_EN
  logic [31:0] ld_addr, fwd_val, t_ld_addr, t_fwd_val;
  logic        fwd_hit, t_fwd_hit;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] sb_q[$];

  always #5 sys_clk = ~sys_clk;

  mem_w_commit #(.DEPTH(4), .TIMEOUT(255)) u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .mem_w_op(mem_w_op), .mem_w_mem_addr(mem_w_mem_addr), .mem_w_mem_val(mem_w_mem_val),
    .mem_w_ready(mem_w_ready), .bus_w_req(bus_w_req), .bus_w_addr(bus_w_addr),
    .bus_w_data(bus_w_data), .bus_w_ack(bus_w_ack),
`ifdef MEM_W_FWD_EN
    .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_val(fwd_val),
`endif
    .idle(idle), .err_ovf(err_ovf), .err_tmo(err_tmo), .err_clr(err_clr)
  );

  mem_w_commit #(.DEPTH(4), .TIMEOUT(4)) u_dut_tmo (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .mem_w_op(t_op), .mem_w_mem_addr(t_addr), .mem_w_mem_val(t_val),
    .mem_w_ready(t_ready), .bus_w_req(t_req), .bus_w_addr(t_baddr),
    .bus_w_data(t_bdata), .bus_w_ack(t_ack),
`ifdef MEM_W_FWD_EN
    .ld_addr(t_ld_addr), .fwd_hit(t_fwd_hit), .fwd_val(t_fwd_val),
`endif
    .idle(t_idle), .err_ovf(t_ovf), .err_tmo(t_tmo), .err_clr(t_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
  endtask

  // Drive one store for one cycle; accepted stores are queued as expected bus writes.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit accept);
    mem_w_op       = 1'b1;
    mem_w_mem_addr = a;
    mem_w_mem_val  = d;
    if (accept) sb_q.push_back({a, d});
    tick();
    mem_w_op = 1'b0;
  endtask

  // Bus monitor: sample shortly before each posedge; a req with ack completes a write there.
  always begin
    logic [63:0] exp_w;
    @(negedge sys_clk);
    #4;
    if (sys_rst_n && bus_w_req && bus_w_ack) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_write", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_w = sb_q.pop_front();
        check("sb_wr_addr", bus_w_addr, exp_w[63:32]);
        check("sb_wr_data", bus_w_data, exp_w[31:0]);
      end
    end
  end

  initial begin
    sys_rst_n = 1'b0; mem_w_op = 1'b0; mem_w_mem_addr = '0; mem_w_mem_val = '0;
    bus_w_ack = 1'b0; err_clr = 1'b0;
    t_op = 1'b0; t_addr = '0; t_val = '0; t_ack = 1'b0; t_clr = 1'b0;
`ifdef MEM_W_FWD_EN
    ld_addr = '0; t_ld_addr = '0;
`endif
    #1;
    check("rst_req",   32'(bus_w_req),   32'd0);
    check("rst_addr",  bus_w_addr,       32'd0);
    check("rst_data",  bus_w_data,       32'd0);
    check("rst_ready", 32'(mem_w_ready), 32'd1);
    check("rst_idle",  32'(idle),        32'd1);
    check("rst_ovf",   32'(err_ovf),     32'd0);
    check("rst_tmo",   32'(err_tmo),     32'd0);
    tick(); tick();
    sys_rst_n = 1'b1;
    tick();

    // Single store, ack tied high.
    bus_w_ack = 1'b1;
    store(32'h100, 32'hDEADBEEF, 1'b1);
    check("t1_req_push_cycle", 32'(bus_w_req), 32'd0);
    check("t1_not_idle",       32'(idle),      32'd0);
    tick();
    check("t1_req_rise", 32'(bus_w_req), 32'd1);
    check("t1_addr",     bus_w_addr,     32'h100);
    check("t1_data",     bus_w_data,     32'hDEADBEEF);
    tick();
    check("t1_req_fall", 32'(bus_w_req), 32'd0);
    check("t1_idle",     32'(idle),      32'd1);
    bus_w_ack = 1'b0;

    // Fill with ack low, overflow, then drain back-to-back.
    for (int i = 0; i < 4; i++) begin
      check("t2_ready_filling", 32'(mem_w_ready), 32'd1);
      store(32'h1000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b1);
    end
    check("t2_ready_full", 32'(mem_w_ready), 32'd0);
    check("t2_ovf_clear",  32'(err_ovf),     32'd0);
    store(32'h2000, 32'hBAD0BAD0, 1'b0);
    check("t2_ovf_set",    32'(err_ovf),     32'd1);
    check("t2_still_full", 32'(mem_w_ready), 32'd0);
    check("t2_head_held",  bus_w_addr,       32'h1000);
    bus_w_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_req", 32'(bus_w_req), 32'd1);
      tick();
    end
    check("t2_drain_done", 32'(bus_w_req), 32'd0);
    check("t2_drain_idle", 32'(idle),      32'd1);
    bus_w_ack = 1'b0;
    check("t2_ovf_sticky", 32'(err_ovf), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t2_ovf_cleared", 32'(err_ovf), 32'd0);

    // Push and ack in the same cycle with one entry buffered.
    store(32'h300, 32'h11111111, 1'b1);
    tick();
    check("t4_req_launch", 32'(bus_w_req), 32'd1);
    check("t4_addr0",      bus_w_addr,     32'h300);
    bus_w_ack = 1'b1;
    store(32'h304, 32'h22222222, 1'b1);
    check("t4_req_held", 32'(bus_w_req),   32'd1);
    check("t4_addr1",    bus_w_addr,       32'h304);
    check("t4_data1",    bus_w_data,       32'h22222222);
    check("t4_not_idle", 32'(idle),        32'd0);
    check("t4_ready",    32'(mem_w_ready), 32'd1);
    tick();
    check("t4_req_fall", 32'(bus_w_req), 32'd0);
    check("t4_idle",     32'(idle),      32'd1);
    bus_w_ack = 1'b0;

    // Bus timeout on the TIMEOUT=4 instance; ack never asserted.
    t_op = 1'b1; t_addr = 32'h400; t_val = 32'hD0D0D0D0;
    tick();
    t_addr = 32'h404; t_val = 32'hD1D1D1D1;
    tick();
    t_op = 1'b0;
    check("t3_req_rise", 32'(t_req), 32'd1);
    check("t3_addr0",    t_baddr,    32'h400);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_waiting_req", 32'(t_req), 32'd1);
      check("t3_waiting_tmo", 32'(t_tmo), 32'd0);
    end
    tick();
    check("t3_tmo_set",     32'(t_tmo),   32'd1);
    check("t3_req_drop",    32'(t_req),   32'd0);
    check("t3_one_left",    32'(t_idle),  32'd0);
    check("t3_ready",       32'(t_ready), 32'd1);
    t_clr = 1'b1;
    tick();
    t_clr = 1'b0;
    check("t3_tmo_cleared", 32'(t_tmo), 32'd0);
    check("t3_relaunch",    32'(t_req), 32'd1);
    check("t3_addr1",       t_baddr,    32'h404);
    check("t3_data1",       t_bdata,    32'hD1D1D1D1);
    tick(); tick(); tick();
    check("t3_tmo_before_2nd", 32'(t_tmo), 32'd0);
    t_clr = 1'b1;
    tick();
    check("t3_set_beats_clr", 32'(t_tmo),  32'd1);
    check("t3_empty_idle",    32'(t_idle), 32'd1);
    check("t3_req_drop2",     32'(t_req),  32'd0);
    tick();
    t_clr = 1'b0;
    check("t3_tmo_cleared2", 32'(t_tmo), 32'd0);

`ifdef MEM_W_FWD_EN
    store(32'h200, 32'd1, 1'b1);
    store(32'h200, 32'd2, 1'b1);
    store(32'h300, 32'd3, 1'b1);
    ld_addr = 32'h200;
    #1;
    check("t6_hit_young",  32'(fwd_hit), 32'd1);
    check("t6_val_young",  fwd_val,      32'd2);
    ld_addr = 32'h204;
    #1;
    check("t6_miss_hit",   32'(fwd_hit), 32'd0);
    check("t6_miss_val",   fwd_val,      32'd0);
    ld_addr = 32'h300;
    #1;
    check("t6_hit_other",  fwd_val,      32'd3);
    bus_w_ack = 1'b1;
    tick(); tick(); tick(); tick();
    bus_w_ack = 1'b0;
    check("t6_drained",    32'(idle),    32'd1);
`endif

    // Reset in the middle of a busy transfer with three entries buffered.
    store(32'h500, 32'hC0C0C0C0, 1'b0);
    store(32'h504, 32'hC1C1C1C1, 1'b0);
    store(32'h508, 32'hC2C2C2C2, 1'b0);
    check("t5_busy", 32'(bus_w_req), 32'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("t5_rst_req",   32'(bus_w_req),   32'd0);
    check("t5_rst_addr",  bus_w_addr,       32'd0);
    check("t5_rst_data",  bus_w_data,       32'd0);
    check("t5_rst_ready", 32'(mem_w_ready), 32'd1);
    check("t5_rst_idle",  32'(idle),        32'd1);
    tick(); tick();
    sys_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t5_no_req",  32'(bus_w_req), 32'd0);
      check("t5_idle",    32'(idle),      32'd1);
    end

    check("sb_all_written", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
